// File: rtl/drum_audio_bridge.sv
// Bridges the drum column array to the stereo audio FIFOs: captures the center node once per
// iteration, writes it left then right, and re-arms the columns for the next time step.
module drum_audio_bridge #(
  parameter int unsigned AUDIO_SHIFT = 14,
  parameter int unsigned MIN_SPACE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] center_node,
  input  logic        columns_done,
  input  logic [7:0]  fifo_space_left,
  input  logic [7:0]  fifo_space_right,
  output logic [31:0] audio_data,
  output logic        audio_write_left,
  output logic        audio_write_right,
  output logic        iteration_enable,
  output logic [15:0] iter_cycles,
  output logic [31:0] sample_count,
  output logic [31:0] stall_cycles
);

  localparam logic [2:0] StWaitDone  = 3'd0;
  localparam logic [2:0] StCapture   = 3'd1;
  localparam logic [2:0] StWaitSpace = 3'd2;
  localparam logic [2:0] StWriteL    = 3'd3;
  localparam logic [2:0] StWriteR    = 3'd4;
  localparam logic [2:0] StStart     = 3'd5;
  localparam logic [2:0] StArm       = 3'd6;

  localparam logic [7:0] MinSpace = 8'(MIN_SPACE);

  logic [2:0]  state_q, state_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [1:0]  arm_cnt_q, arm_cnt_d;
  logic        repulse_q, repulse_d;
  logic [31:0] audio_data_q, audio_data_d;
  logic [15:0] iter_cycles_q, iter_cycles_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        wr_left_q, wr_left_d;
  logic        wr_right_q, wr_right_d;
  logic        enable_q, enable_d;

  logic signed [31:0] center_ext;
  logic [31:0]        center_scaled;
  logic [15:0]        run_inc;
  logic               space_ok;

  assign center_ext    = {{14{center_node[17]}}, center_node};
  assign center_scaled = center_ext <<< AUDIO_SHIFT;
  assign run_inc       = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;
  assign space_ok      = (fifo_space_left >= MinSpace) && (fifo_space_right >= MinSpace);

  always_comb begin
    state_d        = state_q;
    run_cnt_d      = run_cnt_q;
    arm_cnt_d      = arm_cnt_q;
    repulse_d      = repulse_q;
    audio_data_d   = audio_data_q;
    iter_cycles_d  = iter_cycles_q;
    sample_count_d = sample_count_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      StWaitDone: begin
        if (columns_done) begin
          iter_cycles_d = run_cnt_q;
          run_cnt_d     = 16'd0;
          state_d       = StCapture;
        end else begin
          run_cnt_d = run_inc;
        end
      end
      StCapture: begin
        audio_data_d = center_scaled;
        state_d      = StWaitSpace;
      end
      StWaitSpace: begin
        if (space_ok) state_d = StWriteL;
        else          stall_cycles_d = stall_cycles_q + 32'd1;
      end
      StWriteL: state_d = StWriteR;
      StWriteR: begin
        sample_count_d = sample_count_q + 32'd1;
        state_d        = StStart;
      end
      StStart: begin
        // A re-pulse keeps timing the same iteration rather than restarting the count.
        run_cnt_d = repulse_q ? run_inc : 16'd1;
        repulse_d = 1'b0;
        arm_cnt_d = 2'd0;
        state_d   = StArm;
      end
      StArm: begin
        run_cnt_d = run_inc;
        if (!columns_done) begin
          state_d = StWaitDone;
        end else if (arm_cnt_q == 2'd3) begin
          repulse_d = 1'b1;
          state_d   = StStart;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      default: state_d = StWaitDone;
    endcase
  end

  // Strobes are registered from the next state so they align exactly with their states.
  always_comb begin
    wr_left_d  = (state_d == StWriteL);
    wr_right_d = (state_d == StWriteR);
    enable_d   = (state_d == StStart);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StWaitDone;
      run_cnt_q      <= 16'd0;
      arm_cnt_q      <= 2'd0;
      repulse_q      <= 1'b0;
      audio_data_q   <= 32'd0;
      iter_cycles_q  <= 16'd0;
      sample_count_q <= 32'd0;
      stall_cycles_q <= 32'd0;
      wr_left_q      <= 1'b0;
      wr_right_q     <= 1'b0;
      enable_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      arm_cnt_q      <= arm_cnt_d;
      repulse_q      <= repulse_d;
      audio_data_q   <= audio_data_d;
      iter_cycles_q  <= iter_cycles_d;
      sample_count_q <= sample_count_d;
      stall_cycles_q <= stall_cycles_d;
      wr_left_q      <= wr_left_d;
      wr_right_q     <= wr_right_d;
      enable_q       <= enable_d;
    end
  end

  assign audio_data        = audio_data_q;
  assign audio_write_left  = wr_left_q;
  assign audio_write_right = wr_right_q;
  assign iteration_enable  = enable_q;
  assign iter_cycles       = iter_cycles_q;
  assign sample_count      = sample_count_q;
  assign stall_cycles      = stall_cycles_q;

endmodule
